mux_arb_reg: RTL and testbench
==============================

// Module: mux_arb_reg
// PURPOSE
//  Parametrised N-channel arbitrating mux with a registered output stage.
//  Generalises the 2/3-input select muxes: selection is made internally by a
//  round-robin arbiter, not by an external sel, and each input uses valid/ready.
//  Sits between multiple producers (e.g. writeback/forwarding sources, memory
//  request ports) and one shared consumer in the pipelined datapath.
// PARAMETERS
//  LENGTH   32  data width per channel (bits)
//  N         4  number of input channels, 2..16
//  SEL_W    $clog2(N) (localparam)  width of channel index
// PORTS
//  clk        in   1          clock, all state on rising edge
//  rst        in   1          asynchronous, active-high reset
//  in_valid   in   N          per-channel request valid
//  in_data    in   N*LENGTH   channel i on bits [i*LENGTH +: LENGTH]
//  in_ready   out  N          per-channel accept (one-hot or zero)
//  out_valid  out  1          output register holds a valid word
//  out_data   out  LENGTH     registered selected data
//  out_sel    out  SEL_W      index of channel that produced out_data
//  out_ready  in   1          consumer accepts out_data this cycle
// BEHAVIOUR
//  - Reset (async, rst=1): out_valid=0, out_data=0, out_sel=0, last-grant ptr=N-1
//    (channel 0 highest priority after reset); in_ready=0 while rst=1.
//  - load = ~out_valid | out_ready (output register empty or draining this cycle).
//  - Arbitration (combinational): among asserted in_valid, grant the first index
//    searching ptr+1, ptr+2, ... modulo N (wrap N-1 -> 0). grant one-hot or zero.
//  - in_ready = grant & {N{load}}; transfer on channel i when in_valid[i]&in_ready[i].
//  - On transfer: out_data<=in_data[i], out_sel<=i, out_valid<=1, ptr<=i. Latency 1.
//  - load=1 and no in_valid: out_valid<=0; out_data/out_sel hold; ptr holds.
//  - out_valid=1 and out_ready=0 (stall): out_* hold stable, in_ready=0, ptr holds.
//  - Simultaneous drain and fill (out_ready=1, some in_valid): new word loaded
//    same edge, no bubble; full throughput of 1 word/cycle.
//  - in_ready never depends on in_valid of the same channel only through grant;
//    no combinational path from out_ready to out_data/out_valid.
//  - Fairness: with all N valid continuously and out_ready=1, grants cycle
//    0,1,..,N-1,0 ... ; a waiting channel is served within N transfers.
//  - Producers must hold in_valid/in_data until accepted; dropping in_valid
//    unaccepted is allowed (no state is kept for it).
//  - Reset asserted mid-transfer: output word discarded, all state to reset values.
// CONFIGURATION
//  MUX_ARB_FIXED_PRIO_EN defined: arbiter is fixed priority, lowest index wins;
//    ptr register removed; fairness guarantee void.
//  MUX_ARB_FIXED_PRIO_EN undefined (default): round-robin as above.
// TESTING
//  1. Reset: rst=1 mid-stream with out_valid=1 -> out_valid=0, out_data=0,
//     out_sel=0, in_ready=0 immediately (async).
//  2. Single channel: N=4, in_valid=4'b0100, data2=32'hDEAD_BEEF, out_ready=1 ->
//     in_ready=4'b0100; next cycle out_valid=1, out_data=DEADBEEF, out_sel=2.
//  3. Round robin: in_valid=4'b1111 held, out_ready=1 for 8 cycles ->
//     out_sel sequence 0,1,2,3,0,1,2,3 with out_valid=1 every cycle.
//  4. Stall: out_valid=1, out_ready=0 for 3 cycles, in_valid=4'b0011 ->
//     in_ready=0, out_data/out_sel unchanged; release -> next grant continues
//     from ptr+1.
//  5. Wrap: last grant=3, in_valid=4'b1001 -> grant channel 0, then channel 3.
//  6. MUX_ARB_FIXED_PRIO_EN defined, in_valid=4'b1111 held 4 cycles ->
//     out_sel=0 every cycle; channel 3 never granted.

Source files
------------

// File: rtl/mux_arb_reg.sv
// mux_arb_reg: N-channel valid/ready arbitrating mux with a registered output.
// A round-robin arbiter picks one requesting channel per cycle. The winner's word
// is captured into a single output register that drains through out_valid/out_ready.
// Build option MUX_ARB_FIXED_PRIO_EN: when it is defined, the arbiter uses fixed
// priority (lowest index wins) and the last-grant pointer register is removed.
module mux_arb_reg #(
  parameter int LENGTH = 32,
  parameter int N      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          in_valid,
  input  logic [N*LENGTH-1:0]   in_data,
  output logic [N-1:0]          in_ready,
  output logic                  out_valid,
  output logic [LENGTH-1:0]     out_data,
  output logic [$clog2(N)-1:0]  out_sel,
  input  logic                  out_ready
);

  localparam int SEL_W = $clog2(N);

  logic              out_valid_q, out_valid_d;
  logic [LENGTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0]  out_sel_q,   out_sel_d;
`ifndef MUX_ARB_FIXED_PRIO_EN
  logic [SEL_W-1:0]  ptr_q,       ptr_d;
`endif

  logic              load;
  logic [N-1:0]      grant;
  logic              grant_any;
  logic [SEL_W-1:0]  grant_idx;
  logic [SEL_W-1:0]  idx;
  logic [LENGTH-1:0] sel_data;
  logic [LENGTH-1:0] ch_data [N];

  for (genvar g = 0; g < N; g++) begin : g_ch
    assign ch_data[g] = in_data[g*LENGTH +: LENGTH];
  end

  // The output register can take a new word when it is empty or is being drained this cycle.
  assign load = ~out_valid_q | out_ready;

  // Arbiter: the first requester after the last grant wins (round robin), or the lowest index wins (fixed priority).
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
`ifdef MUX_ARB_FIXED_PRIO_EN
      idx = SEL_W'(k);
`else
      idx = SEL_W'((int'(ptr_q) + 1 + k) % N);
`endif
      if (!grant_any && in_valid[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  assign sel_data = ch_data[grant_idx];
  // Reset gates in_ready because the registers sit in their reset state while rst is high, which would otherwise let load and a grant through.
  assign in_ready = grant & {N{load & ~rst}};

  // Next-state logic for the output register and the last-grant pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
`ifndef MUX_ARB_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif
    if (load) begin
      out_valid_d = grant_any;
      if (grant_any) begin
        out_data_d = sel_data;
        out_sel_d  = grant_idx;
`ifndef MUX_ARB_FIXED_PRIO_EN
        ptr_d      = grant_idx;
`endif
      end
    end
  end

  // State registers. Reset clears the output word and points the arbiter at channel N-1, which gives channel 0 first priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
`ifndef MUX_ARB_FIXED_PRIO_EN
      ptr_q       <= SEL_W'(N - 1);
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
`ifndef MUX_ARB_FIXED_PRIO_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_arb_reg.sv
// Directed testbench for mux_arb_reg with N=4 and LENGTH=32.
// Test vectors come from a table. Reset and asynchronous reset are checked in hand-written sequences.
module tb_mux_arb_reg;

  localparam int LENGTH = 32;
  localparam int N      = 4;

  logic              clk;
  logic              rst;
  logic [N-1:0]      in_valid;
  logic [N*LENGTH-1:0] in_data;
  logic [N-1:0]      in_ready;
  logic              out_valid;
  logic [LENGTH-1:0] out_data;
  logic [1:0]        out_sel;
  logic              out_ready;

  mux_arb_reg #(.LENGTH(LENGTH), .N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sel(out_sel), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   iv;
    logic [127:0] data;
    logic         ordy;
    logic [3:0]   ir;
    logic         ov;
    logic [31:0]  od;
    logic [1:0]   os;
  } vec_t;

  localparam logic [127:0] D_STD  = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
  localparam logic [127:0] D_BEEF = {32'h4444_4444, 32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111};

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] iv, input logic [127:0] d, input logic ordy,
                     input logic [3:0] ir, input logic ov, input logic [31:0] od,
                     input logic [1:0] os);
    vec_t v;
    v.iv = iv; v.data = d; v.ordy = ordy; v.ir = ir; v.ov = ov; v.od = od; v.os = os;
    vecs.push_back(v);
  endtask

  initial begin
`ifndef MUX_ARB_FIXED_PRIO_EN
    // idle after reset
    add(4'b0000, D_STD,  1'b1, 4'b0000, 1'b0, 32'h0,         2'd0);
    // single channel 2
    add(4'b0100, D_BEEF, 1'b1, 4'b0100, 1'b1, 32'hDEAD_BEEF, 2'd2);
    // empty: valid drops, data/sel hold
    add(4'b0000, D_STD,  1'b1, 4'b0000, 1'b0, 32'hDEAD_BEEF, 2'd2);
    // set last grant to 3
    add(4'b1000, D_STD,  1'b1, 4'b1000, 1'b1, 32'h4444_4444, 2'd3);
    // round robin, 8 back-to-back transfers
    add(4'b1111, D_STD,  1'b1, 4'b0001, 1'b1, 32'h1111_1111, 2'd0);
    add(4'b1111, D_STD,  1'b1, 4'b0010, 1'b1, 32'h2222_2222, 2'd1);
    add(4'b1111, D_STD,  1'b1, 4'b0100, 1'b1, 32'h3333_3333, 2'd2);
    add(4'b1111, D_STD,  1'b1, 4'b1000, 1'b1, 32'h4444_4444, 2'd3);
    add(4'b1111, D_STD,  1'b1, 4'b0001, 1'b1, 32'h1111_1111, 2'd0);
    add(4'b1111, D_STD,  1'b1, 4'b0010, 1'b1, 32'h2222_2222, 2'd1);
    add(4'b1111, D_STD,  1'b1, 4'b0100, 1'b1, 32'h3333_3333, 2'd2);
    add(4'b1111, D_STD,  1'b1, 4'b1000, 1'b1, 32'h4444_4444, 2'd3);
    // stall for 3 cycles
    add(4'b0011, D_STD,  1'b0, 4'b0000, 1'b1, 32'h4444_4444, 2'd3);
    add(4'b0011, D_STD,  1'b0, 4'b0000, 1'b1, 32'h4444_4444, 2'd3);
    add(4'b0011, D_STD,  1'b0, 4'b0000, 1'b1, 32'h4444_4444, 2'd3);
    // release: continue after ptr=3
    add(4'b0011, D_STD,  1'b1, 4'b0001, 1'b1, 32'h1111_1111, 2'd0);
    add(4'b0011, D_STD,  1'b1, 4'b0010, 1'b1, 32'h2222_2222, 2'd1);
    // wrap from 3 to 0, then back to 3
    add(4'b1000, D_STD,  1'b1, 4'b1000, 1'b1, 32'h4444_4444, 2'd3);
    add(4'b1001, D_STD,  1'b1, 4'b0001, 1'b1, 32'h1111_1111, 2'd0);
    add(4'b1001, D_STD,  1'b1, 4'b1000, 1'b1, 32'h4444_4444, 2'd3);
    // stall then drain to empty
    add(4'b1001, D_STD,  1'b0, 4'b0000, 1'b1, 32'h4444_4444, 2'd3);
    add(4'b0000, D_STD,  1'b1, 4'b0000, 1'b0, 32'h4444_4444, 2'd3);
    // empty register loads even when out_ready=0
    add(4'b0010, D_STD,  1'b0, 4'b0010, 1'b1, 32'h2222_2222, 2'd1);
`else
    add(4'b1111, D_STD,  1'b1, 4'b0001, 1'b1, 32'h1111_1111, 2'd0);
    add(4'b1111, D_STD,  1'b1, 4'b0001, 1'b1, 32'h1111_1111, 2'd0);
    add(4'b1111, D_STD,  1'b1, 4'b0001, 1'b1, 32'h1111_1111, 2'd0);
    add(4'b1111, D_STD,  1'b1, 4'b0001, 1'b1, 32'h1111_1111, 2'd0);
    add(4'b1010, D_STD,  1'b1, 4'b0010, 1'b1, 32'h2222_2222, 2'd1);
    add(4'b1000, D_STD,  1'b0, 4'b0000, 1'b1, 32'h2222_2222, 2'd1);
    add(4'b1000, D_STD,  1'b1, 4'b1000, 1'b1, 32'h4444_4444, 2'd3);
    add(4'b0000, D_STD,  1'b1, 4'b0000, 1'b0, 32'h4444_4444, 2'd3);
`endif

    // reset state while rst is held, with requests present
    rst = 1'b1; in_valid = 4'b1111; in_data = D_STD; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_out_data",  out_data,           32'h0);
    check("rst_out_sel",   {30'b0, out_sel},   32'h0);
    check("rst_in_ready",  {28'b0, in_ready},  32'h0);
    @(negedge clk);
    rst = 1'b0; in_valid = 4'b0000;

    foreach (vecs[i]) begin
      @(negedge clk);
      in_valid = vecs[i].iv; in_data = vecs[i].data; out_ready = vecs[i].ordy;
      #1;
      check($sformatf("v%0d_in_ready", i), {28'b0, in_ready}, {28'b0, vecs[i].ir});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].ov});
      check($sformatf("v%0d_out_data", i),  out_data,           vecs[i].od);
      check($sformatf("v%0d_out_sel", i),   {30'b0, out_sel},   {30'b0, vecs[i].os});
    end

    // asynchronous reset mid-stream while the output register is full
    @(negedge clk);
    in_valid = 4'b1111; out_ready = 1'b1; in_data = D_STD;
    @(posedge clk);
    #1;
    check("pre_async_out_valid", {31'b0, out_valid}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("async_out_valid", {31'b0, out_valid}, 32'h0);
    check("async_out_data",  out_data,           32'h0);
    check("async_out_sel",   {30'b0, out_sel},   32'h0);
    check("async_in_ready",  {28'b0, in_ready},  32'h0);
    @(posedge clk);
    #1;
    check("async_hold_out_valid", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {28'b0, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    check("post_rst_out_sel",  {30'b0, out_sel},  32'h0);
    check("post_rst_out_data", out_data,          32'h1111_1111);
    check("post_rst_out_valid", {31'b0, out_valid}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
